visor_poke_mailbox: RTL and testbench

//  Visor-to-target data path: the opposite direction of the peek register. The visor pushes 16-bit

---
 rtl/visor_poke_mailbox.sv | 97 +++++++++
 tb/tb_visor_poke_mailbox.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/visor_poke_mailbox.sv
// Visor-to-target poke mailbox: show-ahead FIFO of 16-bit words with a pollable status word.
// Latency: a word pushed on edge N is visible on tg_data right after edge N (0-cycle read).
// Backpressure: poke_ready = !full from registered count; a flush drops any word offered that cycle.
//
// Ports:
//   sysclk, sysreset_n      clock and asynchronous active-low reset
//   poke_data/valid/ready   visor push handshake
//   flush                   synchronous clear of pointers, count and underflow
//   tg_data_rd, tg_data     target pop strobe and head word (0 when empty)
//   tg_stat_rd, tg_stat     target status strobe and status word
//                           {not_empty, full, underflow, 5'b0, count[7:0]}
//   empty                   no words held
module visor_poke_mailbox #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        sysclk,
    input  logic        sysreset_n,
    input  logic [15:0] poke_data,
    input  logic        poke_valid,
    output logic        poke_ready,
    input  logic        flush,
    input  logic        tg_data_rd,
    output logic [15:0] tg_data,
    input  logic        tg_stat_rd,
    output logic [15:0] tg_stat,
    output logic        empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          underflow_q, underflow_d;

    logic full;
    logic push;
    logic pop;

    // Flags come only from registered count, so ready has no input-to-output path.
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign poke_ready = !full;

    assign push = poke_valid && poke_ready;
    assign pop  = tg_data_rd && !empty;

    assign tg_data = empty ? 16'h0000 : mem[rd_ptr_q];
    assign tg_stat = {!empty, full, underflow_q, 5'b0_0000, 8'(count_q)};

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;

        if (flush) begin
            // Flush beats push and pop: an offered word is dropped.
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            underflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

            if (push && !pop)      count_d = count_q + (AW+1)'(1);
            else if (pop && !push) count_d = count_q - (AW+1)'(1);

            // Status read clears the sticky bit, but a fresh underflow in the same cycle wins.
            if (tg_stat_rd)              underflow_d = 1'b0;
            if (tg_data_rd && empty)     underflow_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately unreset; the pointers alone define what is valid.
    always_ff @(posedge sysclk) begin
        if (push && !flush) mem[wr_ptr_q] <= poke_data;
    end

endmodule

// File: tb/tb_visor_poke_mailbox.sv
module tb_visor_poke_mailbox;

    logic        sysclk = 1'b0;
    logic        sysreset_n;
    logic [15:0] poke_data;
    logic        poke_valid;
    logic        poke_ready;
    logic        flush;
    logic        tg_data_rd;
    logic [15:0] tg_data;
    logic        tg_stat_rd;
    logic [15:0] tg_stat;
    logic        empty;

    int checks = 0;
    int errors = 0;

    visor_poke_mailbox #(.DEPTH(8), .AW(3)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .poke_data  (poke_data),
        .poke_valid (poke_valid),
        .poke_ready (poke_ready),
        .flush      (flush),
        .tg_data_rd (tg_data_rd),
        .tg_data    (tg_data),
        .tg_stat_rd (tg_stat_rd),
        .tg_stat    (tg_stat),
        .empty      (empty)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        int rd_idx;
        sysreset_n = 1'b0;
        poke_data  = 16'h0000;
        poke_valid = 1'b0;
        flush      = 1'b0;
        tg_data_rd = 1'b0;
        tg_stat_rd = 1'b0;
        tick();
        tick();
        sysreset_n = 1'b1;
        tick();

        // 1: reset mid-clock with words held clears everything immediately
        poke_valid = 1'b1;
        poke_data  = 16'h1111;
        tick();
        poke_data  = 16'h2222;
        tick();
        poke_valid = 1'b0;
        chk("pre_rst_stat", tg_stat, 16'h8002);
        #3;
        sysreset_n = 1'b0;
        #1;
        chk("rst_ready", {15'b0, poke_ready}, 16'h0001);
        chk("rst_empty", {15'b0, empty}, 16'h0001);
        chk("rst_stat", tg_stat, 16'h0000);
        chk("rst_data", tg_data, 16'h0000);
        tick();
        sysreset_n = 1'b1;
        tick();

        // 2: ordering
        poke_valid = 1'b1;
        poke_data  = 16'h1234;
        tick();
        poke_data  = 16'hABCD;
        tick();
        poke_data  = 16'h0001;
        tick();
        poke_valid = 1'b0;
        chk("ord_stat", tg_stat, 16'h8003);
        chk("ord_head", tg_data, 16'h1234);
        tg_data_rd = 1'b1;
        chk("ord_pop0", tg_data, 16'h1234);
        tick();
        chk("ord_pop1", tg_data, 16'hABCD);
        tick();
        chk("ord_pop2", tg_data, 16'h0001);
        tick();
        tg_data_rd = 1'b0;
        chk("ord_empty", {15'b0, empty}, 16'h0001);
        chk("ord_stat_end", tg_stat, 16'h0000);

        // 3: full, held-off push, pop+push when full
        poke_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            poke_data = 16'(i);
            tick();
        end
        poke_data = 16'hDEAD;
        chk("full_ready", {15'b0, poke_ready}, 16'h0000);
        chk("full_stat", tg_stat, 16'hC008);
        tick();
        chk("full_held_stat", tg_stat, 16'hC008);
        chk("full_held_head", tg_data, 16'h0000);
        tg_data_rd = 1'b1;
        tick();
        tg_data_rd = 1'b0;
        chk("full_poppush_stat", tg_stat, 16'h8007);
        chk("full_poppush_ready", {15'b0, poke_ready}, 16'h0001);
        chk("full_poppush_head", tg_data, 16'h0001);
        tick();
        poke_valid = 1'b0;
        chk("full_dead_acc", tg_stat, 16'hC008);
        tg_data_rd = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("full_drain", tg_data, 16'(i));
            tick();
        end
        chk("full_dead_last", tg_data, 16'hDEAD);
        tick();
        tg_data_rd = 1'b0;
        chk("full_empty", {15'b0, empty}, 16'h0001);

        // 4: underflow
        tg_data_rd = 1'b1;
        chk("uf_data", tg_data, 16'h0000);
        tick();
        tg_data_rd = 1'b0;
        chk("uf_stat", tg_stat, 16'h2000);
        tg_stat_rd = 1'b1;
        chk("uf_stat_read", tg_stat, 16'h2000);
        tick();
        tg_stat_rd = 1'b0;
        chk("uf_cleared", tg_stat, 16'h0000);
        tg_data_rd = 1'b1;
        poke_valid = 1'b1;
        poke_data  = 16'h5555;
        tick();
        tg_data_rd = 1'b0;
        poke_valid = 1'b0;
        chk("uf_push_stat", tg_stat, 16'hA001);
        chk("uf_push_data", tg_data, 16'h5555);
        tg_data_rd = 1'b1;
        tg_stat_rd = 1'b1;
        tick();
        tg_data_rd = 1'b0;
        tg_stat_rd = 1'b0;
        chk("uf_clean", tg_stat, 16'h0000);

        // 5: interleaved traffic across pointer wrap
        rd_idx = 0;
        for (int c = 0; c < 26; c++) begin
            poke_valid = (c < 20);
            poke_data  = 16'h0100 + 16'(c);
            tg_data_rd = (c >= 6);
            if (tg_data_rd) begin
                chk("wrap_data", tg_data, 16'h0100 + 16'(rd_idx));
                rd_idx++;
            end
            chk("wrap_cnt_le8", {15'b0, (tg_stat[7:0] <= 8'd8)}, 16'h0001);
            tick();
        end
        poke_valid = 1'b0;
        tg_data_rd = 1'b0;
        chk("wrap_popped", 16'(rd_idx), 16'd20);
        chk("wrap_empty", {15'b0, empty}, 16'h0001);

        // 6: flush with a simultaneous push
        poke_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            poke_data = 16'h2000 + 16'(i);
            tick();
        end
        chk("fl_pre_stat", tg_stat, 16'h8005);
        poke_data = 16'hBEEF;
        flush     = 1'b1;
        tick();
        flush      = 1'b0;
        poke_valid = 1'b0;
        chk("fl_empty", {15'b0, empty}, 16'h0001);
        chk("fl_stat", tg_stat, 16'h0000);
        tg_data_rd = 1'b1;
        chk("fl_no_beef", tg_data, 16'h0000);
        tick();
        tg_data_rd = 1'b0;
        chk("fl_uf_stat", tg_stat, 16'h2000);
        poke_valid = 1'b1;
        poke_data  = 16'h7777;
        tick();
        poke_valid = 1'b0;
        chk("fl_after_data", tg_data, 16'h7777);
        chk("fl_after_stat", tg_stat, 16'hA001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
